// File: rtl/parity_stream_chk_pkg.sv
// Shared types and helpers for the 16-bit parity datapath family.
// Words wider than PAR_MAX_W bits are not supported by parity_f.
package parity_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam int   PAR_MAX_W = 64;

  // Zero-extended data leaves the XOR reduction unchanged.
  function automatic logic parity_f(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_stream_chk_calc.sv
// Combinational word parity: raw XOR, generated parity and error compare.
module parity_calc
  import parity_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] data,
  input  logic              odd,
  input  logic              par_in,
  output logic              p,
  output logic              e,
  output logic              x
);

  logic [PAR_MAX_W-1:0] data_ext_s;

  // Widen the word to the helper's fixed argument width.
  always_comb begin
    data_ext_s = {PAR_MAX_W{1'b0}};
    data_ext_s[DATA_W-1:0] = data;
  end

  assign x = ^data;
  assign p = parity_f(data_ext_s, odd);
  assign e = (par_in != p);

endmodule

// File: rtl/parity_stream_chk.sv
// Streaming parity generator/checker with frame accumulation, a one-stage
// output register, and a saturating error counter with sticky flag.
module parity_stream_chk
  import parity_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  output logic              out_last,
  output logic              out_frame_par,
  output logic              out_frame_err,
  input  logic              clr,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state_r;
  logic   acc_x_r;
  logic   acc_e_r;
  logic   p_s;
  logic   e_s;
  logic   x_s;
  logic   accept_s;
  logic   frame_par_s;
  logic   frame_err_s;

  parity_calc #(.DATA_W(DATA_W)) u_calc (
    .data   (in_data),
    .odd    (odd_sel),
    .par_in (in_par),
    .p      (p_s),
    .e      (e_s),
    .x      (x_s)
  );

  assign in_ready = rst_n & (~out_valid | out_ready);
  assign accept_s = in_valid & in_ready;

  // Accumulators are zero while IDLE, so one expression covers both states.
  always_comb begin
    frame_par_s = 1'b0;
    frame_err_s = 1'b0;
    if (in_last) begin
      frame_par_s = (acc_x_r ^ x_s) ^ odd_sel;
      frame_err_s = acc_e_r | e_s;
    end else begin
      frame_par_s = 1'b0;
      frame_err_s = 1'b0;
    end
  end

  // Output register stage: load on accept, drop valid on drain, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= {DATA_W{1'b0}};
      out_par       <= 1'b0;
      out_err       <= 1'b0;
      out_last      <= 1'b0;
      out_frame_par <= 1'b0;
      out_frame_err <= 1'b0;
    end else if (accept_s) begin
      out_valid     <= 1'b1;
      out_data      <= in_data;
      out_par       <= p_s;
      out_err       <= e_s;
      out_last      <= in_last;
      out_frame_par <= frame_par_s;
      out_frame_err <= frame_err_s;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

  // Frame FSM and accumulators; the last word closes the frame and clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_x_r <= 1'b0;
      acc_e_r <= 1'b0;
    end else if (accept_s) begin
      case (state_r)
        IDLE: begin
          if (in_last) begin
            acc_x_r <= 1'b0;
            acc_e_r <= 1'b0;
          end else begin
            state_r <= FRAME;
            acc_x_r <= x_s;
            acc_e_r <= e_s;
          end
        end
        FRAME: begin
          if (in_last) begin
            state_r <= IDLE;
            acc_x_r <= 1'b0;
            acc_e_r <= 1'b0;
          end else begin
            acc_x_r <= acc_x_r ^ x_s;
            acc_e_r <= acc_e_r | e_s;
          end
        end
        default: begin
          state_r <= IDLE;
          acc_x_r <= 1'b0;
          acc_e_r <= 1'b0;
        end
      endcase
    end
  end

  // Error status; clear takes priority over a coincident word error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt    <= {CNT_W{1'b0}};
      err_sticky <= 1'b0;
    end else if (clr) begin
      err_cnt    <= {CNT_W{1'b0}};
      err_sticky <= 1'b0;
    end else if (accept_s && e_s) begin
      err_sticky <= 1'b1;
      if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_stream_chk.sv
// Directed bench for parity_stream_chk with a 2-bit error counter so that
// saturation is reachable in a handful of words.
module tb_parity_stream_chk;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              odd_sel;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_par;
  logic              out_err;
  logic              out_last;
  logic              out_frame_par;
  logic              out_frame_err;
  logic              clr;
  logic [CNT_W-1:0]  err_cnt;
  logic              err_sticky;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  parity_stream_chk #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .odd_sel       (odd_sel),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_par        (in_par),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_par       (out_par),
    .out_err       (out_err),
    .out_last      (out_last),
    .out_frame_par (out_frame_par),
    .out_frame_err (out_frame_err),
    .clr           (clr),
    .err_cnt       (err_cnt),
    .err_sticky    (err_sticky)
  );

  // Present one word for exactly one edge, then sample 1 time unit later.
  task automatic drive(input logic [DATA_W-1:0] d, input logic par,
                       input logic last, input logic odd);
    in_data  = d;
    in_par   = par;
    in_last  = last;
    odd_sel  = odd;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; odd_sel = 1'b0; in_valid = 1'b0; in_data = '0;
    in_par = 1'b0; in_last = 1'b0; out_ready = 1'b1; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 16'h0000) begin miscompares++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    vectors++; if (err_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_sticky: got %b want 0", err_sticky); end
    rst_n = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_even_single();
    drive(16'h000B, 1'b1, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL even_valid: got %b want 1", out_valid); end
    vectors++; if (out_data !== 16'h000B) begin miscompares++; $display("FAIL even_data: got %h want 000b", out_data); end
    vectors++; if (out_par !== 1'b1) begin miscompares++; $display("FAIL even_par: got %b want 1", out_par); end
    vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL even_err: got %b want 0", out_err); end
    vectors++; if (out_frame_par !== 1'b1) begin miscompares++; $display("FAIL even_frame_par: got %b want 1", out_frame_par); end
    vectors++; if (out_frame_err !== 1'b0) begin miscompares++; $display("FAIL even_frame_err: got %b want 0", out_frame_err); end
    vectors++; if (err_cnt !== 2'd0) begin miscompares++; $display("FAIL even_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_odd_error();
    drive(16'h000A, 1'b0, 1'b1, 1'b1);
    vectors++; if (out_par !== 1'b1) begin miscompares++; $display("FAIL odd_par: got %b want 1", out_par); end
    vectors++; if (out_err !== 1'b1) begin miscompares++; $display("FAIL odd_err: got %b want 1", out_err); end
    vectors++; if (out_frame_par !== 1'b1) begin miscompares++; $display("FAIL odd_frame_par: got %b want 1", out_frame_par); end
    vectors++; if (out_frame_err !== 1'b1) begin miscompares++; $display("FAIL odd_frame_err: got %b want 1", out_frame_err); end
    vectors++; if (err_cnt !== 2'd1) begin miscompares++; $display("FAIL odd_cnt: got %0d want 1", err_cnt); end
    vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL odd_sticky: got %b want 1", err_sticky); end
  endtask

  task automatic test_frame();
    logic [DATA_W-1:0] words [3] = '{16'h0001, 16'h0003, 16'h0007};
    logic              pars  [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(words[i], pars[i], (i == 2), 1'b0);
      vectors++; if (out_par !== pars[i]) begin miscompares++; $display("FAIL frame_par_w%0d: got %b want %b", i, out_par, pars[i]); end
      vectors++; if (out_last !== (i == 2)) begin miscompares++; $display("FAIL frame_last_w%0d: got %b", i, out_last); end
      vectors++; if (out_frame_par !== 1'b0) begin miscompares++; $display("FAIL frame_fpar_w%0d: got %b want 0", i, out_frame_par); end
      vectors++; if (out_frame_err !== 1'b0) begin miscompares++; $display("FAIL frame_ferr_w%0d: got %b want 0", i, out_frame_err); end
    end
    // Error on the middle word must surface as a frame error on the last word.
    drive(16'h0001, 1'b1, 1'b0, 1'b0);
    drive(16'h0003, 1'b1, 1'b0, 1'b0);
    vectors++; if (out_err !== 1'b1) begin miscompares++; $display("FAIL ferr_mid_err: got %b want 1", out_err); end
    vectors++; if (out_frame_err !== 1'b0) begin miscompares++; $display("FAIL ferr_mid_ferr: got %b want 0", out_frame_err); end
    drive(16'h0001, 1'b1, 1'b1, 1'b0);
    vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL ferr_last_err: got %b want 0", out_err); end
    vectors++; if (out_frame_err !== 1'b1) begin miscompares++; $display("FAIL ferr_last_ferr: got %b want 1", out_frame_err); end
    vectors++; if (out_frame_par !== 1'b0) begin miscompares++; $display("FAIL ferr_last_fpar: got %b want 0", out_frame_par); end
    vectors++; if (err_cnt !== 2'd2) begin miscompares++; $display("FAIL ferr_cnt: got %0d want 2", err_cnt); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_last = 1'b1; odd_sel = 1'b0;
    in_data = 16'h00FF; in_par = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_data !== 16'h00FF) begin miscompares++; $display("FAIL b2b_first: got %h want 00ff", out_data); end
    in_data = 16'h0100; in_par = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_data !== 16'h0100) begin miscompares++; $display("FAIL b2b_second: got %h want 0100", out_data); end
    vectors++; if (out_par !== 1'b1) begin miscompares++; $display("FAIL b2b_par: got %b want 1", out_par); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    drive(16'h1234, 1'b1, 1'b1, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00F0; in_par = 1'b1; in_last = 1'b1; odd_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_c%0d: got %b want 0", i, in_ready); end
      vectors++; if (out_data !== 16'h1234) begin miscompares++; $display("FAIL bp_hold_c%0d: got %h want 1234", i, out_data); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_c%0d: got %b want 1", i, out_valid); end
      vectors++; if (err_cnt !== 2'd2) begin miscompares++; $display("FAIL bp_cnt_c%0d: got %0d want 2", i, err_cnt); end
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (out_data !== 16'h00F0) begin miscompares++; $display("FAIL bp_accept_data: got %h want 00f0", out_data); end
    vectors++; if (out_err !== 1'b1) begin miscompares++; $display("FAIL bp_accept_err: got %b want 1", out_err); end
    vectors++; if (err_cnt !== 2'd3) begin miscompares++; $display("FAIL bp_accept_cnt: got %0d want 3", err_cnt); end
  endtask

  task automatic test_saturate_clear();
    logic [CNT_W-1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    vectors++; if (err_cnt !== 2'd0) begin miscompares++; $display("FAIL clr_cnt: got %0d want 0", err_cnt); end
    vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL clr_sticky: got %b want 0", err_sticky); end
    for (int i = 0; i < 5; i++) begin
      drive(16'h0003, 1'b1, 1'b1, 1'b0);
      vectors++; if (err_cnt !== exp_cnt[i]) begin miscompares++; $display("FAIL sat_cnt_w%0d: got %0d want %0d", i, err_cnt, exp_cnt[i]); end
    end
    vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL sat_sticky: got %b want 1", err_sticky); end
    clr = 1'b1;
    drive(16'h0003, 1'b1, 1'b1, 1'b0);
    clr = 1'b0;
    vectors++; if (err_cnt !== 2'd0) begin miscompares++; $display("FAIL clr_err_cnt: got %0d want 0", err_cnt); end
    vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL clr_err_sticky: got %b want 0", err_sticky); end
    vectors++; if (out_err !== 1'b1) begin miscompares++; $display("FAIL clr_err_out: got %b want 1", out_err); end
  endtask

  task automatic test_mid_frame_reset();
    drive(16'h0001, 1'b1, 1'b0, 1'b0);
    drive(16'h0003, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mrst_ready: got %b want 0", in_ready); end
    vectors++; if ({out_valid, out_par, out_err, out_last, out_frame_par, out_frame_err} !== 6'b0)
      begin miscompares++; $display("FAIL mrst_flags: got %b want 000000", {out_valid, out_par, out_err, out_last, out_frame_par, out_frame_err}); end
    vectors++; if (out_data !== 16'h0000) begin miscompares++; $display("FAIL mrst_data: got %h want 0000", out_data); end
    vectors++; if ({err_cnt, err_sticky} !== 3'b0) begin miscompares++; $display("FAIL mrst_status: got %b want 000", {err_cnt, err_sticky}); end
    rst_n = 1'b1;
    drive(16'h0001, 1'b1, 1'b1, 1'b0);
    vectors++; if (out_frame_par !== 1'b1) begin miscompares++; $display("FAIL mrst_fpar: got %b want 1", out_frame_par); end
    vectors++; if (out_frame_err !== 1'b0) begin miscompares++; $display("FAIL mrst_ferr: got %b want 0", out_frame_err); end
    vectors++; if (out_last !== 1'b1) begin miscompares++; $display("FAIL mrst_last: got %b want 1", out_last); end
  endtask

  initial begin
    test_reset();
    test_even_single();
    test_odd_error();
    test_frame();
    test_back_to_back();
    test_backpressure();
    test_saturate_clear();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
